// File: rtl/cia_intc_pkg.sv
// Package cia: shared types and constants for the CIA core.
// Contents:
//   model_t      chip model selector (MOS6526 / MOS8521)
//   reg4_t       register address type
//   reg8_t       register data type
//   ICR_ADDR     address of the interrupt control register ($D)
//   ICR_NONE     src_id value meaning "no source pending"
//   icr_phase_t  phase sequencer states of the interrupt controller
package cia;

  typedef enum logic {
    MOS6526 = 1'b0,
    MOS8521 = 1'b1
  } model_t;

  typedef logic [3:0] reg4_t;
  typedef logic [7:0] reg8_t;

  localparam reg4_t      ICR_ADDR = 4'hD;
  localparam logic [2:0] ICR_NONE = 3'd7;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_P1   = 2'd1,
    PH_P2   = 2'd2
  } icr_phase_t;

endpackage

// File: rtl/cia_intc_if.sv
// Register bus seen by the interrupt controller.
// Signals:
//   rd, we  bus read / write qualifiers
//   addr    register address
//   data    write data
//   regs    ICR readback returned to the bus register mux
// Modports: master (bus side), slave (interrupt controller side).
interface cia_intc_if;

  logic       rd;
  logic       we;
  cia::reg4_t addr;
  cia::reg8_t data;
  cia::reg8_t regs;

  modport master (output rd, we, addr, data, input regs);
  modport slave  (input rd, we, addr, data, output regs);

endinterface

// File: rtl/cia_intc_src_delay.sv
// cia_src_delay: NSRC-wide, DEPTH-deep shift register that models the
// MOS6526 source latency. It advances once per phi2 period.
// Ports:
//   clk   system clock
//   res   asynchronous active-high reset, clears every stage
//   en    shift enable (phi2 falling-edge strobe)
//   din   interrupt source strobes entering stage 0
//   dout  last stage (DEPTH-1)
module cia_src_delay #(
  parameter int NSRC  = 5,
  parameter int DEPTH = 1
) (
  input  logic            clk,
  input  logic            res,
  input  logic            en,
  input  logic [NSRC-1:0] din,
  output logic [NSRC-1:0] dout
);

  logic [NSRC-1:0] stage_r [DEPTH];

  // Shift the source history by one stage per phi2 period.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_r[k] <= {NSRC{1'b0}};
      end
    end else if (en) begin
      stage_r[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        stage_r[k] <= stage_r[k-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/cia_intc.sv
// cia_intc: parametrised interrupt controller for the CIA core.
// Latches up to NSRC sources into flags in phase P1, evaluates the masked
// flags in phase P2 and drives irq_n, a priority-encoded source id and a
// one-clk pulse on every irq 0->1 transition.
// Ports:
//   clk       system clock
//   res       asynchronous active-high reset
//   model     chip model (MOS6526 uses the source delay line)
//   phi2_dn   one-clk strobe marking the phi2 falling edge
//   bus       register bus (rd/we/addr/data in, regs = ICR readback out)
//   sources   interrupt source strobes
//   irq_n     active-low interrupt request
//   src_id    lowest pending masked source, ICR_NONE when none
//   irq_rise  one-clk pulse when irq goes 0->1
module cia_intc
  import cia::*;
#(
  parameter int NSRC      = 5,
  parameter int SRC_DELAY = 1,
  parameter int RS_BUG    = 0
) (
  input  logic             clk,
  input  logic             res,
  input  model_t           model,
  input  logic             phi2_dn,
  cia_intc_if.slave        bus,
  input  logic [NSRC-1:0]  sources,
  output logic             irq_n,
  output logic [2:0]       src_id,
  output logic             irq_rise
);

  // The delay line always has at least one stage; with SRC_DELAY = 0 it is
  // simply never selected.
  localparam int DLY_DEPTH = (SRC_DELAY > 0) ? SRC_DELAY : 1;

  // Lowest set bit index of the pending vector, ICR_NONE when empty.
  function automatic logic [2:0] lowest_set(input logic [NSRC-1:0] v);
    logic [2:0] idx;
    idx = ICR_NONE;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  icr_phase_t      phase_r;
  icr_phase_t      phase_nxt_s;
  logic            in_p1_s;
  logic            p2_go_s;
  logic            rd_flags_r;
  logic [NSRC-1:0] mask_r;
  logic [NSRC-1:0] flags_r;
  logic [NSRC-1:0] flags_nxt_s;
  logic [NSRC-1:0] dly_out_s;
  logic [NSRC-1:0] eff_s;
  logic [NSRC-1:0] pend_s;
  logic            irq_r;
  logic [2:0]      src_id_r;
  logic            irq_rise_r;
  logic [7:0]      regs_s;
  logic            icr_sel_s;
  logic            data_unused_s;

  // Write data bits between NSRC and 6 carry no mask bits.
  assign data_unused_s = ^bus.data;

  assign icr_sel_s = (bus.addr == ICR_ADDR);

  cia_src_delay #(
    .NSRC  (NSRC),
    .DEPTH (DLY_DEPTH)
  ) u_src_delay (
    .clk  (clk),
    .res  (res),
    .en   (phi2_dn),
    .din  (sources),
    .dout (dly_out_s)
  );

  // Phase state register.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      phase_r <= PH_IDLE;
    end else begin
      phase_r <= phase_nxt_s;
    end
  end

  // Phase next-state: phi2_dn restarts the sequence from any state.
  always_comb begin
    phase_nxt_s = phase_r;
    if (phi2_dn) begin
      phase_nxt_s = PH_P1;
    end else begin
      case (phase_r)
        PH_IDLE: phase_nxt_s = PH_IDLE;
        PH_P1:   phase_nxt_s = PH_P2;
        PH_P2:   phase_nxt_s = PH_IDLE;
        default: phase_nxt_s = PH_IDLE;
      endcase
    end
  end

  // Phase decode; a P2 interrupted by a new phi2_dn is skipped entirely.
  always_comb begin
    in_p1_s = 1'b0;
    p2_go_s = 1'b0;
    case (phase_r)
      PH_IDLE: begin
        in_p1_s = 1'b0;
        p2_go_s = 1'b0;
      end
      PH_P1: begin
        in_p1_s = 1'b1;
        p2_go_s = 1'b0;
      end
      PH_P2: begin
        in_p1_s = 1'b0;
        p2_go_s = !phi2_dn;
      end
      default: begin
        in_p1_s = 1'b0;
        p2_go_s = 1'b0;
      end
    endcase
  end

  // Effective source vector: delayed only on a MOS6526 with a nonzero delay.
  always_comb begin
    if ((model == MOS6526) && (SRC_DELAY > 0)) begin
      eff_s = dly_out_s;
    end else begin
      eff_s = sources;
    end
  end

  // Flag update rule; RS_BUG decides whether a read-clear beats a new set.
  always_comb begin
    if (RS_BUG != 0) begin
      flags_nxt_s = rd_flags_r ? {NSRC{1'b0}} : (flags_r | eff_s);
    end else begin
      flags_nxt_s = eff_s | (rd_flags_r ? {NSRC{1'b0}} : flags_r);
    end
  end

  assign pend_s = flags_r & mask_r;

  // Bus-side state captured on the phi2 falling edge: read marker and mask.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      rd_flags_r <= 1'b0;
      mask_r     <= {NSRC{1'b0}};
    end else if (phi2_dn) begin
      rd_flags_r <= bus.rd && icr_sel_s;
      if (bus.we && icr_sel_s) begin
        if (bus.data[7]) begin
          mask_r <= mask_r | bus.data[NSRC-1:0];
        end else begin
          mask_r <= mask_r & ~bus.data[NSRC-1:0];
        end
      end
    end
  end

  // Interrupt flags latch in P1.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      flags_r <= {NSRC{1'b0}};
    end else if (in_p1_s) begin
      flags_r <= flags_nxt_s;
    end
  end

  // irq, source id and rise pulse update in P2. Masking alone never drops
  // irq; only a read (or reset) does.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      irq_r      <= 1'b0;
      src_id_r   <= ICR_NONE;
      irq_rise_r <= 1'b0;
    end else begin
      irq_rise_r <= 1'b0;
      if (p2_go_s) begin
        if (rd_flags_r) begin
          irq_r    <= 1'b0;
          src_id_r <= ICR_NONE;
        end else if (|pend_s) begin
          irq_r      <= 1'b1;
          src_id_r   <= lowest_set(pend_s);
          irq_rise_r <= !irq_r;
        end
      end
    end
  end

  // ICR readback: irq in bit 7, flags in the low bits, zeros in between.
  always_comb begin
    regs_s             = 8'h00;
    regs_s[7]          = irq_r;
    regs_s[NSRC-1:0]   = flags_r;
  end

  assign bus.regs = regs_s;
  assign irq_n    = !irq_r;
  assign src_id   = src_id_r;
  assign irq_rise = irq_rise_r;

endmodule

// File: tb/tb_cia_intc.sv
// Directed self-checking bench for cia_intc. Four instances share one
// stimulus stream:
//   d0: NSRC=5, SRC_DELAY=1, RS_BUG=0
//   d1: NSRC=5, SRC_DELAY=2, RS_BUG=0
//   d2: NSRC=5, SRC_DELAY=1, RS_BUG=1
//   d3: NSRC=7, SRC_DELAY=1, RS_BUG=0
module tb_cia_intc;
  import cia::*;

  logic       clk;
  logic       res;
  model_t     model_v;
  logic       phi2_dn;
  logic       rd_v;
  logic       we_v;
  reg4_t      addr_v;
  reg8_t      data_v;
  logic [6:0] src_v;

  logic       irq_n0, irq_n1, irq_n2, irq_n3;
  logic [2:0] sid0, sid1, sid2, sid3;
  logic       rise0, rise1, rise2, rise3;

  int n_checks;
  int n_errors;

  cia_intc_if bus0 ();
  cia_intc_if bus1 ();
  cia_intc_if bus2 ();
  cia_intc_if bus3 ();

  assign bus0.rd = rd_v;  assign bus0.we = we_v;  assign bus0.addr = addr_v;  assign bus0.data = data_v;
  assign bus1.rd = rd_v;  assign bus1.we = we_v;  assign bus1.addr = addr_v;  assign bus1.data = data_v;
  assign bus2.rd = rd_v;  assign bus2.we = we_v;  assign bus2.addr = addr_v;  assign bus2.data = data_v;
  assign bus3.rd = rd_v;  assign bus3.we = we_v;  assign bus3.addr = addr_v;  assign bus3.data = data_v;

  cia_intc #(.NSRC(5), .SRC_DELAY(1), .RS_BUG(0)) d0 (
    .clk(clk), .res(res), .model(model_v), .phi2_dn(phi2_dn), .bus(bus0),
    .sources(src_v[4:0]), .irq_n(irq_n0), .src_id(sid0), .irq_rise(rise0));
  cia_intc #(.NSRC(5), .SRC_DELAY(2), .RS_BUG(0)) d1 (
    .clk(clk), .res(res), .model(model_v), .phi2_dn(phi2_dn), .bus(bus1),
    .sources(src_v[4:0]), .irq_n(irq_n1), .src_id(sid1), .irq_rise(rise1));
  cia_intc #(.NSRC(5), .SRC_DELAY(1), .RS_BUG(1)) d2 (
    .clk(clk), .res(res), .model(model_v), .phi2_dn(phi2_dn), .bus(bus2),
    .sources(src_v[4:0]), .irq_n(irq_n2), .src_id(sid2), .irq_rise(rise2));
  cia_intc #(.NSRC(7), .SRC_DELAY(1), .RS_BUG(0)) d3 (
    .clk(clk), .res(res), .model(model_v), .phi2_dn(phi2_dn), .bus(bus3),
    .sources(src_v), .irq_n(irq_n3), .src_id(sid3), .irq_rise(rise3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one clk cycle, then step to #1 after the next edge.
  task automatic cyc(input logic p, input logic [6:0] s, input logic r,
                     input logic w, input logic [7:0] d);
    phi2_dn = p; src_v = s; rd_v = r; we_v = w; data_v = d;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    phi2_dn = 1'b0; src_v = 7'h00; rd_v = 1'b0; we_v = 1'b0; data_v = 8'h00;
    res = 1'b1;
    @(posedge clk); #1;
    res = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    res = 1'b1;
    model_v = MOS8521;
    phi2_dn = 1'b0; rd_v = 1'b0; we_v = 1'b0; addr_v = 4'hD; data_v = 8'h00; src_v = 7'h00;
    repeat (2) @(posedge clk);
    #1 res = 1'b0;

    // Reset state
    chk("rst_regs",  bus0.regs, 8'h00);
    chk("rst_irqn",  {7'd0, irq_n0}, 8'h01);
    chk("rst_sid",   {5'd0, sid0}, 8'h07);
    chk("rst_rise",  {7'd0, rise0}, 8'h00);
    chk("rst_regs3", bus3.regs, 8'h00);

    // MOS8521: enable source 0, pulse it in P1
    cyc(1'b1, 7'h00, 1'b0, 1'b1, 8'h81);
    cyc(1'b0, 7'h01, 1'b0, 1'b0, 8'h00);
    chk("a_regs_n2", bus0.regs, 8'h01);
    chk("a_irqn_n2", {7'd0, irq_n0}, 8'h01);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    chk("a_irqn_n3", {7'd0, irq_n0}, 8'h00);
    chk("a_sid_n3",  {5'd0, sid0}, 8'h00);
    chk("a_rise_n3", {7'd0, rise0}, 8'h01);
    chk("a_regs_n3", bus0.regs, 8'h81);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    chk("a_rise_n4", {7'd0, rise0}, 8'h00);
    // Read $D clears flags in P1 and irq in P2
    cyc(1'b1, 7'h00, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    chk("a_rd_regs_p2", bus0.regs, 8'h80);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    chk("a_rd_regs", bus0.regs, 8'h00);
    chk("a_rd_irqn", {7'd0, irq_n0}, 8'h01);
    chk("a_rd_sid",  {5'd0, sid0}, 8'h07);

    // Re-raise irq, then reset asynchronously in the middle of P1
    cyc(1'b1, 7'h00, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 7'h01, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    chk("r_pre_irqn", {7'd0, irq_n0}, 8'h00);
    cyc(1'b1, 7'h00, 1'b0, 1'b0, 8'h00);
    phi2_dn = 1'b0; src_v = 7'h01;
    res = 1'b1;
    #1;
    chk("r_async_irqn", {7'd0, irq_n0}, 8'h01);
    chk("r_async_regs", bus0.regs, 8'h00);
    chk("r_async_sid",  {5'd0, sid0}, 8'h07);
    res = 1'b0;
    @(posedge clk); #1;
    chk("r_no_p1_regs", bus0.regs, 8'h00);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    chk("r_no_p2_irqn", {7'd0, irq_n0}, 8'h01);
    chk("r_no_p2_regs", bus0.regs, 8'h00);

    // MOS6526 delay line: source valid from P1 through the next phi2_dn
    do_reset();
    model_v = MOS6526;
    cyc(1'b1, 7'h00, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 7'h01, 1'b0, 1'b0, 8'h00);
    chk("b_k0_d0", bus0.regs, 8'h00);
    chk("b_k0_d1", bus1.regs, 8'h00);
    cyc(1'b0, 7'h01, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 7'h01, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    chk("b_k1_d0", bus0.regs, 8'h01);
    chk("b_k1_d1", bus1.regs, 8'h00);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 7'h00, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    chk("b_k2_d1", bus1.regs, 8'h01);

    // Read coincident with a set of source 2
    do_reset();
    model_v = MOS8521;
    cyc(1'b1, 7'h00, 1'b0, 1'b1, 8'h84);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 7'h00, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 7'h04, 1'b0, 1'b0, 8'h00);
    chk("c_nobug_regs", bus0.regs, 8'h04);
    chk("c_bug_regs",   bus2.regs, 8'h00);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    chk("c_rd_irqn", {7'd0, irq_n0}, 8'h01);
    chk("c_rd_sid",  {5'd0, sid0}, 8'h07);
    cyc(1'b1, 7'h00, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    chk("c_next_irqn", {7'd0, irq_n0}, 8'h00);
    chk("c_next_sid",  {5'd0, sid0}, 8'h02);
    chk("c_next_rise", {7'd0, rise0}, 8'h01);
    chk("c_bug_regs2", bus2.regs, 8'h00);
    chk("c_bug_irqn",  {7'd0, irq_n2}, 8'h01);

    // NSRC=7 priority, mask clears do not drop irq
    do_reset();
    cyc(1'b1, 7'h00, 1'b0, 1'b1, 8'hFF);
    cyc(1'b0, 7'h50, 1'b0, 1'b0, 8'h00);
    chk("d_regs_n2", bus3.regs, 8'h50);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    chk("d_regs_n3", bus3.regs, 8'hD0);
    chk("d_sid",     {5'd0, sid3}, 8'h04);
    chk("d_rise",    {7'd0, rise3}, 8'h01);
    cyc(1'b1, 7'h00, 1'b0, 1'b1, 8'h10);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    chk("d_m10_irqn", {7'd0, irq_n3}, 8'h00);
    chk("d_m10_sid",  {5'd0, sid3}, 8'h06);
    chk("d_m10_rise", {7'd0, rise3}, 8'h00);
    cyc(1'b1, 7'h00, 1'b0, 1'b1, 8'h40);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    chk("d_m40_irqn", {7'd0, irq_n3}, 8'h00);
    chk("d_m40_sid",  {5'd0, sid3}, 8'h06);
    chk("d_m40_regs", bus3.regs, 8'hD0);
    cyc(1'b1, 7'h00, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    chk("d_rd_regs_p2", bus3.regs, 8'h80);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    chk("d_rd_regs", bus3.regs, 8'h00);
    chk("d_rd_irqn", {7'd0, irq_n3}, 8'h01);
    chk("d_rd_sid",  {5'd0, sid3}, 8'h07);

    // Back-to-back phi2_dn at 2-clk spacing skips P2
    do_reset();
    cyc(1'b1, 7'h00, 1'b0, 1'b1, 8'h81);
    cyc(1'b0, 7'h01, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 7'h00, 1'b0, 1'b0, 8'h00);
    chk("e_skip1_irqn", {7'd0, irq_n0}, 8'h01);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 7'h00, 1'b0, 1'b0, 8'h00);
    chk("e_skip2_irqn", {7'd0, irq_n0}, 8'h01);
    chk("e_skip2_regs", bus0.regs, 8'h01);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 7'h00, 1'b0, 1'b0, 8'h00);
    chk("e_ok_irqn", {7'd0, irq_n0}, 8'h00);
    chk("e_ok_sid",  {5'd0, sid0}, 8'h00);
    chk("e_ok_rise", {7'd0, rise0}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cia_intc.md
# cia_intc

Parametrised interrupt controller for the CIA core: a generalisation of the fixed 5-source ICR. It latches up to 7 interrupt sources into flags, applies a set/clear mask written via register $D and drives `irq_n`. It adds a configurable MOS6526 source delay depth, optional emulation of the read/set race bug, a registered priority-encoded source ID and a one-cycle IRQ-assert pulse. It sits between the timer/TOD/SDR/FLAG source logic and the bus register mux.

## Interface
Parameters:
- `NSRC`, default 5: number of interrupt sources. Legal range is 1..7.
- `SRC_DELAY`, default 1: source delay in phi2 ticks applied when `model == cia::MOS6526`. Legal range is 0..3.
- `RS_BUG`, default 0: when 1, a flag clear by read wins over a simultaneous set (emulates lost flags).

Ports (reset is asynchronous, active-high):
- `clk`  in  1  system clock.
- `res`  in  1  asynchronous active-high reset.
- `model`  in  cia::model_t  chip model.
- `phi2_dn`  in  1  one-clk strobe marking the phi2 falling edge.
- `rd`, `we`  in  1 each  bus read and write.
- `addr`  in  cia::reg4_t  register address.
- `data`  in  cia::reg8_t  write data.
- `sources`  in  NSRC  interrupt source strobes.
- `regs`  out  cia::reg8_t  ICR readback: {irq, zeros, flags[NSRC-1:0]}.
- `irq_n`  out  1  equals ~irq.
- `src_id`  out  3  lowest active masked source. Value 7 means none.
- `irq_rise`  out  1  one-clk pulse when irq goes 0→1.

## Operation
- Phase sequencer `phase` has states IDLE, P1, P2.
  - `phi2_dn` forces P1, with priority over all other transitions.
  - P1 → P2. P2 → IDLE. IDLE holds.
- On `phi2_dn`:
  - `rd_flags <= rd && addr == cia::ICR_ADDR`.
  - The delay line shifts: stage0 <= `sources`, stage k <= stage k-1.
- Mask write happens on `phi2_dn && we && addr == ICR_ADDR`.
  - If `data[7]` = 1: `mask |= data[NSRC-1:0]`.
  - If `data[7]` = 0: `mask &= ~data[NSRC-1:0]`.
- Effective source `eff`:
  - MOS6526 with SRC_DELAY > 0: delay-line stage SRC_DELAY-1.
  - Otherwise: `sources` taken directly.
- In P1, for each bit i:
  - RS_BUG = 0: if `eff[i]`, flag <= 1; else if `rd_flags`, flag <= 0.
  - RS_BUG = 1: if `rd_flags`, flag <= 0; else if `eff[i]`, flag <= 1.
- In P2:
  - If `rd_flags`: irq <= 0, `src_id` <= 7.
  - Else if `|(flags & mask)`: irq <= 1, and `src_id` <= index of the lowest set bit of flags & mask.
- `irq_rise` is registered. It is 1 for exactly the clk following the P2 edge where irq went 0→1.
- Unused `regs` bits [6:NSRC] read 0. Mask bits ≥ NSRC are ignored.
- Asynchronous reset clears flags, mask, irq, the delay line, `rd_flags` and `irq_rise`, sets phase to IDLE and `src_id` to 7.
  - Therefore `irq_n` = 1 and `regs` = 8'h00 immediately.
  - Reset mid-sequence abandons the pending P1/P2.

## Timing
- Let cycle n be the cycle in which `phi2_dn` = 1.
  - Phase is P1 in n+1 and P2 in n+2.
  - Flags are visible in `regs` from n+2.
  - irq, `irq_n`, `src_id` and `irq_rise` change from n+3.
- MOS6526 adds SRC_DELAY phi2 periods of source latency. MOS8521 adds none.
- A mask write in cycle n takes effect in the P2 of the same phi2 period.
  - Enabling a pending flag asserts irq at n+3.
  - Clearing a mask bit never deasserts irq. Only a read or reset deasserts it.
- A phi2 period of at least 3 clk is required.
  - If `phi2_dn` arrives in P1 or P2, the sequence restarts at P1 and the old P2 is skipped.
- A read cycle clears irq in that period's P2, even if sources are active. The new flags then raise irq in the following phi2 period.

## Structure
- Package `cia` gains:
  - `localparam ICR_ADDR = 4'hD`.
  - `typedef enum logic [1:0] {PH_IDLE, PH_P1, PH_P2} icr_phase_t`.
  - `localparam ICR_NONE = 3'd7`.
- Sub-module `cia_src_delay` holds the NSRC-wide, SRC_DELAY-deep shift register, enabled by `phi2_dn`, with async reset.
- The priority encoder is a function in `cia_intc`.

## Test plan
- Reset: assert `res` asynchronously mid-P1 → `irq_n` = 1, `regs` = 00, `src_id` = 7 within the same cycle, and no P2 action follows.
- MOS8521, NSRC = 5: write $D = 8'h81, then pulse `sources[0]` → `regs` = 01 at n+2, and `irq_n` = 0, `src_id` = 0, `irq_rise` pulse at n+3. Read $D → `regs` = 00 after that period's P2.
- MOS6526, SRC_DELAY = 2: source strobe → flag appears exactly 2 phi2 periods later than in the MOS8521 run.
- Read coincident with a set of `sources[2]`:
  - RS_BUG = 0 → flag bit 2 survives and irq asserts in the next period.
  - RS_BUG = 1 → flag is lost and `regs` = 00.
- NSRC = 7, mask = 7F, flags 4 and 6 set → `src_id` = 4, `regs` = 8'hD0. Write $D = 8'h10 → irq stays 1 until read.
- Back-to-back `phi2_dn` at a 2-clk spacing → no P2 executes, so irq only updates once the spacing returns to ≥ 3 clk.
